dual_issue_scheduler: RTL and testbench
=======================================

DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

Interface
REQ-001 Parameter: INST_W, default 32, instruction width.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 fetch_valid  in  1  fetch presents an instruction pair.
REQ-005 fetch_inst0  in  INST_W  older instruction of the pair.
REQ-006 fetch_inst1  in  INST_W  younger instruction of the pair.
REQ-007 fetch_ready  out  1  scheduler accepts the pair this cycle (combinational).
REQ-008 stall  in  1  downstream cannot accept; freezes all scheduler state.
REQ-009 flush  in  1  taken branch/jal resolved; discards all scheduler state.
REQ-010 issue_a_valid / issue_a_inst  out  1 / INST_W  registered issue to pipe A (ALU, branch, jal).
REQ-011 issue_b_valid / issue_b_inst  out  1 / INST_W  registered issue to pipe B (ALU, load, store).
REQ-012 held_valid  out  1  a younger instruction is parked in the hold buffer.

Function
REQ-013 Class by opcode[6:0]: 0110011/0010011 = ALU (either pipe); 1100011/1101111 = CTL (A only); 0000011/0100011 = MEM (B only); any other = ILL.
REQ-014 Source reads: R, branch and store read rs1 and rs2; I-type and load read rs1; jal reads none; x0 is never a hazard source.
REQ-015 Dest writes: R, I, load and jal write rd; branch and store write none; rd = x0 counts as no write.
REQ-016 Candidates: if held_valid, c0 = hold buffer and c1 = none, with fetch_ready = 0; otherwise c0/c1 = fetch_inst0/1 when fetch_valid.
REQ-017 Pairing: c0 and c1 issue together only if all hold: classes map to different pipes; c0 is not CTL; c1 does not read c0's rd (RAW); c0 and c1 do not write the same rd (WAW).
REQ-018 Steering: ALU+ALU -> c0 to A, c1 to B; an A-only or B-only instruction takes its own pipe and the ALU partner takes the other.
REQ-019 Split: when pairing fails, c0 issues alone and c1 is written to the hold buffer; the next cycle issues the held instruction alone.
REQ-020 ILL instructions are consumed without issue and never set the hold buffer.
REQ-021 Load-use: ld_rd_q holds rd of a load issued on the previous edge; it is cleared after one cycle.
REQ-022 If c0 reads ld_rd_q, the scheduler issues nothing that cycle and fetch_ready = 0.
REQ-023 If only c1 reads ld_rd_q, c0 issues alone and c1 goes to the hold buffer.
REQ-024 Latency: a pair accepted at edge N appears on the issue outputs after edge N, for exactly one cycle unless stalled.
REQ-025 An issue_x_valid with no instruction steered to that pipe is 0; its issue_x_inst is then 0.
REQ-026 stall = 1: issue registers, hold buffer and ld_rd_q hold their values, and fetch_ready = 0.
REQ-027 flush = 1 (priority over stall and fetch): next edge clears both issue valids, held_valid and ld_rd_q; fetch_ready = 0 that cycle.
REQ-028 State machine, two states: EMPTY (no hold) -> HOLD on split; HOLD -> EMPTY when the held instruction issues or on flush.

Reset
REQ-029 rst = 1 at an edge: state EMPTY; issue_a_valid, issue_b_valid and held_valid = 0; issue_a_inst and issue_b_inst = 0; ld_rd_q = 0.
REQ-030 rst has priority over flush and stall; reset in mid-split drops the held instruction.

Structure
REQ-031 Shared package: opcode constants, the class enum {ALU, CTL, MEM, ILL}, and the pipe-select enum; decoder modules reuse the same opcode constants.
REQ-032 Sub-module inst_classifier: combinational; outputs class, rs1/rs2 read-enables, rd write-enable and register fields; instantiated once per candidate.

Verification
REQ-033 add x1,x2,x3 + addi x4,x5,1 -> both issue next cycle: add on A, addi on B; held_valid = 0.
REQ-034 add x1,x2,x3 + sub x6,x1,x7 -> add on A alone; sub issues alone on the following cycle; fetch_ready = 0 during HOLD.
REQ-035 lw x5,0(x2) + beq x1,x3 -> beq on A and lw on B in the same cycle; then fetch add x6,x5,x1 -> one bubble cycle, then add issues.
REQ-036 beq x1,x2 + addi x3,x3,1 -> beq issues alone and addi is held; flush in the next cycle -> no issue of addi, held_valid = 0.
REQ-037 lw + sw pair -> split: lw on B, then sw on B next cycle; stall asserted 3 cycles mid-split -> outputs frozen, then resume unchanged.
REQ-038 Opcode 0x7F + add -> add issues alone, nothing held; rst asserted while in HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dual_issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler: opcodes, instruction classes,
// pipe selection and scheduler state.
package dual_issue_scheduler_pkg;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_CTL,
        CLS_MEM,
        CLS_ILL
    } inst_class_e;

    typedef enum logic [1:0] {
        PIPE_NONE,
        PIPE_A,
        PIPE_B
    } pipe_sel_e;

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } sched_state_e;

    // Pipe an instruction takes when issuing on its own; a lone ALU op goes to A.
    function automatic pipe_sel_e home_pipe(input inst_class_e cls);
        case (cls)
            CLS_ALU: return PIPE_A;
            CLS_CTL: return PIPE_A;
            CLS_MEM: return PIPE_B;
            default: return PIPE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_inst_classifier.sv
// Combinational decode of one candidate: class, register fields and the
// read/write enables used for hazard checks (x0 never counts).
module inst_classifier
    import dual_issue_scheduler_pkg::*;
#(
    parameter int unsigned INST_W = 32
) (
    input  logic [INST_W-1:0] inst,
    output inst_class_e       cls,
    output logic              rs1_en,
    output logic              rs2_en,
    output logic              rd_en,
    output logic              is_load,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd
);

    logic [6:0] opcode;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_used;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign rd          = inst[11:7];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = ^{inst[INST_W-1:25], inst[14:12]};

    always_comb begin
        cls      = CLS_ILL;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_used  = 1'b0;
        is_load  = 1'b0;
        case (opcode)
            OP_ALU_R: begin
                cls      = CLS_ALU;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                rd_used  = 1'b1;
            end
            OP_ALU_I: begin
                cls      = CLS_ALU;
                rs1_used = 1'b1;
                rd_used  = 1'b1;
            end
            OP_BRANCH: begin
                cls      = CLS_CTL;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_JAL: begin
                cls     = CLS_CTL;
                rd_used = 1'b1;
            end
            OP_LOAD: begin
                cls      = CLS_MEM;
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                is_load  = 1'b1;
            end
            OP_STORE: begin
                cls      = CLS_MEM;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign rs1_en = rs1_used && (rs1 != '0);
    assign rs2_en = rs2_used && (rs2 != '0);
    assign rd_en  = rd_used && (rd != '0);

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: pairs fetched instructions onto pipes A/B,
// splits hazardous pairs through a one-entry hold buffer, and inserts load-use bubbles.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [INST_W-1:0] fetch_inst0,
    input  logic [INST_W-1:0] fetch_inst1,
    output logic              fetch_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              issue_a_valid,
    output logic [INST_W-1:0] issue_a_inst,
    output logic              issue_b_valid,
    output logic [INST_W-1:0] issue_b_inst,
    output logic              held_valid
);

    sched_state_e      state_q;
    logic [INST_W-1:0] hold_q;
    logic [4:0]        ld_rd_q;

    logic              c0_valid;
    logic              c1_valid;
    logic [INST_W-1:0] c0_inst;
    logic [INST_W-1:0] c1_inst;

    inst_class_e c0_cls, c1_cls;
    logic        c0_rs1_en, c0_rs2_en, c0_rd_en, c0_is_load;
    logic        c1_rs1_en, c1_rs2_en, c1_rd_en, c1_is_load;
    logic [4:0]  c0_rs1, c0_rs2, c0_rd;
    logic [4:0]  c1_rs1, c1_rs2, c1_rd;

    logic c0_live, c1_live;
    logic c0_reads_ld, c1_reads_ld;
    logic raw, waw, pipe_conflict, can_pair;
    logic block, park;
    pipe_sel_e sel0, sel1;

    logic              nxt_a_valid, nxt_b_valid;
    logic [INST_W-1:0] nxt_a_inst, nxt_b_inst;
    logic [4:0]        nxt_ld_rd;
    sched_state_e      nxt_state;
    logic [INST_W-1:0] nxt_hold;

    assign held_valid = (state_q == ST_HOLD);
    assign c0_valid   = held_valid || fetch_valid;
    assign c1_valid   = !held_valid && fetch_valid;
    assign c0_inst    = held_valid ? hold_q : fetch_inst0;
    assign c1_inst    = fetch_inst1;

    inst_classifier #(.INST_W(INST_W)) u_class0 (
        .inst(c0_inst), .cls(c0_cls), .rs1_en(c0_rs1_en), .rs2_en(c0_rs2_en),
        .rd_en(c0_rd_en), .is_load(c0_is_load), .rs1(c0_rs1), .rs2(c0_rs2), .rd(c0_rd)
    );

    inst_classifier #(.INST_W(INST_W)) u_class1 (
        .inst(c1_inst), .cls(c1_cls), .rs1_en(c1_rs1_en), .rs2_en(c1_rs2_en),
        .rd_en(c1_rd_en), .is_load(c1_is_load), .rs1(c1_rs1), .rs2(c1_rs2), .rd(c1_rd)
    );

    assign c0_live = c0_valid && (c0_cls != CLS_ILL);
    assign c1_live = c1_valid && (c1_cls != CLS_ILL);

    assign c0_reads_ld = (ld_rd_q != '0) &&
                         ((c0_rs1_en && c0_rs1 == ld_rd_q) || (c0_rs2_en && c0_rs2 == ld_rd_q));
    assign c1_reads_ld = (ld_rd_q != '0) &&
                         ((c1_rs1_en && c1_rs1 == ld_rd_q) || (c1_rs2_en && c1_rs2 == ld_rd_q));

    assign raw           = c0_rd_en && ((c1_rs1_en && c1_rs1 == c0_rd) || (c1_rs2_en && c1_rs2 == c0_rd));
    assign waw           = c0_rd_en && c1_rd_en && (c0_rd == c1_rd);
    assign pipe_conflict = (c0_cls == c1_cls) && (c0_cls != CLS_ALU);
    assign can_pair      = !pipe_conflict && (c0_cls != CLS_CTL) && !raw && !waw && !c1_reads_ld;

    assign block       = c0_live && c0_reads_ld;
    assign fetch_ready = !held_valid && !stall && !flush && !block;

    always_comb begin
        sel0 = PIPE_NONE;
        sel1 = PIPE_NONE;
        park = 1'b0;
        if (!block) begin
            if (c0_live) begin
                sel0 = home_pipe(c0_cls);
            end
            if (c1_live) begin
                if (c0_live) begin
                    if (can_pair) begin
                        // ALU partner yields pipe A to a younger CTL op
                        if (c0_cls == CLS_ALU && c1_cls == CLS_CTL) begin
                            sel0 = PIPE_B;
                        end
                        sel1 = (sel0 == PIPE_A) ? PIPE_B : PIPE_A;
                    end else begin
                        park = 1'b1;
                    end
                end else if (c1_reads_ld) begin
                    park = 1'b1;
                end else begin
                    sel1 = home_pipe(c1_cls);
                end
            end
        end
    end

    always_comb begin
        nxt_a_valid = (sel0 == PIPE_A) || (sel1 == PIPE_A);
        nxt_b_valid = (sel0 == PIPE_B) || (sel1 == PIPE_B);
        nxt_a_inst  = (sel0 == PIPE_A) ? c0_inst : ((sel1 == PIPE_A) ? c1_inst : '0);
        nxt_b_inst  = (sel0 == PIPE_B) ? c0_inst : ((sel1 == PIPE_B) ? c1_inst : '0);

        nxt_ld_rd = '0;
        if (sel0 == PIPE_B && c0_is_load && c0_rd_en) begin
            nxt_ld_rd = c0_rd;
        end else if (sel1 == PIPE_B && c1_is_load && c1_rd_en) begin
            nxt_ld_rd = c1_rd;
        end

        nxt_state = state_q;
        nxt_hold  = hold_q;
        if (state_q == ST_HOLD) begin
            if (sel0 != PIPE_NONE) begin
                nxt_state = ST_EMPTY;
            end
        end else if (park) begin
            nxt_state = ST_HOLD;
            nxt_hold  = c1_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q       <= ST_EMPTY;
            hold_q        <= '0;
            ld_rd_q       <= '0;
            issue_a_valid <= 1'b0;
            issue_a_inst  <= '0;
            issue_b_valid <= 1'b0;
            issue_b_inst  <= '0;
        end else if (!stall) begin
            state_q       <= nxt_state;
            hold_q        <= nxt_hold;
            ld_rd_q       <= nxt_ld_rd;
            issue_a_valid <= nxt_a_valid;
            issue_a_inst  <= nxt_a_inst;
            issue_b_valid <= nxt_b_valid;
            issue_b_inst  <= nxt_b_inst;
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: directed vector table followed by
// randomized traffic compared against a behavioural issue model.
module tb_dual_issue_scheduler;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst, fetch_valid, stall, flush;
    logic [W-1:0] fetch_inst0, fetch_inst1;
    logic         fetch_ready, issue_a_valid, issue_b_valid, held_valid;
    logic [W-1:0] issue_a_inst, issue_b_inst;

    always #5 clk = ~clk;

    dual_issue_scheduler #(.INST_W(W)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1), .fetch_ready(fetch_ready),
        .stall(stall), .flush(flush),
        .issue_a_valid(issue_a_valid), .issue_a_inst(issue_a_inst),
        .issue_b_valid(issue_b_valid), .issue_b_inst(issue_b_inst),
        .held_valid(held_valid)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] enc_ld(input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction
    function automatic logic [31:0] enc_st(input logic [4:0] rs2, rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_br(input logic [4:0] rs1, rs2, input logic [4:0] immlo);
        return {7'd0, rs2, rs1, 3'b000, immlo, 7'h63};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [4:0] rd);
        return {20'h00400, rd, 7'h6F};
    endfunction

    // ---------------- behavioural model ----------------
    // can: pipes the instruction may use (bit0 = A, bit1 = B); 0 means illegal.
    typedef struct {
        logic [1:0] can;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [4:0] dst;
        bit         ld;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] x);
        dec_t d;
        logic [4:0] rd, a, b;
        rd = x[11:7];
        a  = x[19:15];
        b  = x[24:20];
        d  = '{2'b00, 5'd0, 5'd0, 5'd0, 1'b0};
        case (x[6:0])
            7'h33: d = '{2'b11, a, b, rd, 1'b0};
            7'h13: d = '{2'b11, a, 5'd0, rd, 1'b0};
            7'h63: d = '{2'b01, a, b, 5'd0, 1'b0};
            7'h6F: d = '{2'b01, 5'd0, 5'd0, rd, 1'b0};
            7'h03: d = '{2'b10, a, 5'd0, rd, 1'b1};
            7'h23: d = '{2'b10, a, b, 5'd0, 1'b0};
            default: ;
        endcase
        return d;
    endfunction

    function automatic bit reads(input dec_t d, input logic [4:0] r);
        return (r != 5'd0) && (d.s0 == r || d.s1 == r);
    endfunction

    bit          m_held, m_av, m_bv;
    logic [31:0] m_hold, m_ai, m_bi;
    logic [4:0]  m_ld;

    function automatic bit model_ready(input bit fv, input logic [31:0] i0, input bit st, input bit fl);
        dec_t d;
        d = decode(i0);
        return !m_held && !st && !fl && !(fv && d.can != 2'b00 && reads(d, m_ld));
    endfunction

    task automatic model_edge(input bit r, input bit fv, input logic [31:0] i0, input logic [31:0] i1,
                              input bit st, input bit fl);
        logic [31:0] c0, c1;
        dec_t        d0, d1;
        bit          v0, v1, pair, park, fit;
        int          p0, p1;
        if (r || fl) begin
            m_held = 0; m_av = 0; m_bv = 0; m_ai = 0; m_bi = 0; m_ld = 0;
            return;
        end
        if (st) return;
        c0 = m_held ? m_hold : i0;
        c1 = i1;
        d0 = decode(c0);
        d1 = decode(c1);
        v0 = (m_held || fv) && d0.can != 2'b00;
        v1 = (!m_held && fv) && d1.can != 2'b00;
        m_av = 0; m_bv = 0; m_ai = 0; m_bi = 0;
        if (v0 && reads(d0, m_ld)) begin
            m_ld = 0;
            return;
        end
        fit  = (d0.can[0] && d1.can[1]) || (d0.can[1] && d1.can[0]);
        pair = v0 && v1 && fit && d0.can != 2'b01 &&
               !(d0.dst != 0 && reads(d1, d0.dst)) &&
               !(d0.dst != 0 && d0.dst == d1.dst) && !reads(d1, m_ld);
        p0 = 0; p1 = 0; park = 0;
        if (v0) p0 = pair ? ((d0.can[0] && d1.can[1]) ? 1 : 2) : (d0.can[0] ? 1 : 2);
        if (v1) begin
            if (pair) p1 = 3 - p0;
            else if (v0 || reads(d1, m_ld)) park = 1;
            else p1 = d1.can[0] ? 1 : 2;
        end
        if (p0 == 1) begin m_av = 1; m_ai = c0; end
        if (p0 == 2) begin m_bv = 1; m_bi = c0; end
        if (p1 == 1) begin m_av = 1; m_ai = c1; end
        if (p1 == 2) begin m_bv = 1; m_bi = c1; end
        m_ld = 0;
        if (p0 == 2 && d0.ld) m_ld = d0.dst;
        if (p1 == 2 && d1.ld) m_ld = d1.dst;
        m_held = park;
        if (park) m_hold = c1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] a, b, d;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 8))
            0, 1: return enc_r(d, a, b, 7'h00);
            2:    return enc_i(d, a, 12'($urandom_range(0, 4095)));
            3:    return enc_br(a, b, 5'($urandom_range(0, 31)));
            4:    return enc_jal(d);
            5:    return enc_ld(d, a, 12'($urandom_range(0, 64)));
            6:    return enc_st(b, a, 12'($urandom_range(0, 64)));
            7:    return 32'h0000007F;
            default: return {25'($urandom), 7'h37};
        endcase
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          r, fv, st, fl, cr, rdy;
        logic [31:0] i0, i1;
        bit          av;
        logic [31:0] ai;
        bit          bv;
        logic [31:0] bi;
        bit          held;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit r, fv, st, fl, cr, rdy, input logic [31:0] i0, i1,
                                input bit av, input logic [31:0] ai, input bit bv,
                                input logic [31:0] bi, input bit held);
        vec_t v;
        v = '{r, fv, st, fl, cr, rdy, i0, i1, av, ai, bv, bi, held};
        return v;
    endfunction

    initial begin
        logic [31:0] add123, addi451, sub617, lw52, beq13, add651, addi771, beq12, addi331;
        logic [31:0] sw63, ill, addi151, add789, add234, jal1;
        bit          rr, rfv, rst_, rfl, exp_rdy;
        logic [31:0] ri0, ri1;

        add123  = enc_r(1, 2, 3, 7'h00);
        addi451 = enc_i(4, 5, 12'd1);
        sub617  = enc_r(6, 1, 7, 7'h20);
        lw52    = enc_ld(5, 2, 12'd0);
        beq13   = enc_br(1, 3, 5'd8);
        add651  = enc_r(6, 5, 1, 7'h00);
        addi771 = enc_i(7, 7, 12'd1);
        beq12   = enc_br(1, 2, 5'd4);
        addi331 = enc_i(3, 3, 12'd1);
        sw63    = enc_st(6, 3, 12'd4);
        ill     = 32'h0000007F;
        addi151 = enc_i(1, 5, 12'd1);
        add789  = enc_r(7, 8, 9, 7'h00);
        add234  = enc_r(2, 3, 4, 7'h00);
        jal1    = enc_jal(1);

        //              r fv st fl cr rdy  i0       i1        av ai       bv bi       held
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,       0,        0, 0,       0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, add123,  addi451,  1, add123,  1, addi451, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, add123,  sub617,   1, add123,  0, 0,       1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0,        1, sub617,  0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, lw52,    beq13,    1, beq13,   1, lw52,    0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, add651,  addi771,  0, 0,       0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, add651,  addi771,  1, add651,  1, addi771, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, beq12,   addi331,  1, beq12,   0, 0,       1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,       0,        0, 0,       0, 0,       0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0,       0,        0, 0,       0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, lw52,    sw63,     0, 0,       1, lw52,    1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,       0,        0, 0,       1, lw52,    1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,       0,        0, 0,       1, lw52,    1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,       0,        0, 0,       1, lw52,    1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0,        0, 0,       1, sw63,    0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, ill,     add123,   1, add123,  0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, beq12,   addi331,  1, beq12,   0, 0,       1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0,       0,        0, 0,       0, 0,       0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0,       0,        0, 0,       0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, add123,  addi151,  1, add123,  0, 0,       1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,       0,        1, addi151, 0, 0,       0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, lw52,    add789,   1, add789,  1, lw52,    0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, add234,  jal1,     1, jal1,    1, add234,  0));

        rst = 1'b1; fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        fetch_inst0 = '0; fetch_inst1 = '0;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst = vecs[k].r; fetch_valid = vecs[k].fv; stall = vecs[k].st; flush = vecs[k].fl;
            fetch_inst0 = vecs[k].i0; fetch_inst1 = vecs[k].i1;
            #1;
            if (vecs[k].cr) chk($sformatf("vec%0d ready", k), 32'(fetch_ready), 32'(vecs[k].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d a_valid", k), 32'(issue_a_valid), 32'(vecs[k].av));
            chk($sformatf("vec%0d a_inst", k), issue_a_inst, vecs[k].ai);
            chk($sformatf("vec%0d b_valid", k), 32'(issue_b_valid), 32'(vecs[k].bv));
            chk($sformatf("vec%0d b_inst", k), issue_b_inst, vecs[k].bi);
            chk($sformatf("vec%0d held", k), 32'(held_valid), 32'(vecs[k].held));
        end

        // Randomized traffic; the first cycle is a reset so the model starts aligned.
        for (int k = 0; k < 600; k++) begin
            rr   = (k == 0) || ($urandom_range(0, 63) == 0);
            rfv  = ($urandom_range(0, 3) != 0);
            rst_ = ($urandom_range(0, 6) == 0);
            rfl  = ($urandom_range(0, 19) == 0);
            ri0  = rand_inst();
            ri1  = rand_inst();
            @(negedge clk);
            rst = rr; fetch_valid = rfv; stall = rst_; flush = rfl;
            fetch_inst0 = ri0; fetch_inst1 = ri1;
            #1;
            if (k != 0) begin
                exp_rdy = model_ready(rfv, ri0, rst_, rfl);
                chk($sformatf("rnd%0d ready", k), 32'(fetch_ready), 32'(exp_rdy));
            end
            @(posedge clk);
            model_edge(rr, rfv, ri0, ri1, rst_, rfl);
            #1;
            chk($sformatf("rnd%0d a_valid", k), 32'(issue_a_valid), 32'(m_av));
            chk($sformatf("rnd%0d a_inst", k), issue_a_inst, m_ai);
            chk($sformatf("rnd%0d b_valid", k), 32'(issue_b_valid), 32'(m_bv));
            chk($sformatf("rnd%0d b_inst", k), issue_b_inst, m_bi);
            chk($sformatf("rnd%0d held", k), 32'(held_valid), 32'(m_held));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
